// File: rtl/serial_adder_if.sv
// Operand/result bundle between the CPU sequencer and the bit-serial adder.
// Latency: none, wires only.
// Backpressure: none; the slave ignores start while an operation is in flight.
//
// Ports / signals:
//   start, sub, a, b             request and operands (master -> slave)
//   busy, done                   status decoded from the slave's state
//   sum, cout, ovf, zero         registered result and flags (slave -> master)
interface serial_adder_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, ovf, zero
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, ovf, zero
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial add/subtract engine: one full_adder1 cell fed LSB first, carry registered per bit.
// Latency: WIDTH+1 cycles from start accept to done; one operation every WIDTH+2 cycles.
// Backpressure: none; start is only sampled in IDLE, results hold until the next completion.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset (discards any in-flight operation)
//   bus   serial_adder_if slave: start/sub/a/b in, busy/done/sum/cout/ovf/zero out

// Single-bit full adder cell.
module full_adder1 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic [WIDTH-1:0] s_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    logic             fa_sum;
    logic             fa_cout;

    full_adder1 u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Sum bits enter at the MSB so after WIDTH shifts the LSB sits at bit 0.
    assign s_nxt = {fa_sum, s_sr[WIDTH-1:1]};
    assign last  = (cnt == CW'(WIDTH - 1));

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (last)      state_nxt = DONE;
            DONE:                   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: operand/sum shift registers, carry, bit counter, result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            s_sr   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
                        a_sr  <= bus.a;
                        b_sr  <= bus.sub ? ~bus.b : bus.b;
                        carry <= bus.sub;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    s_sr  <= s_nxt;
                    carry <= fa_cout;
                    if (last) begin
                        // carry currently holds the carry into the MSB, so its XOR
                        // with the cell's carry out is the signed overflow.
                        sum_q  <= s_nxt;
                        cout_q <= fa_cout;
                        ovf_q  <= carry ^ fa_cout;
                        zero_q <= (s_nxt == '0);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state == SHIFT);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH=4 and WIDTH=8 against an arithmetic reference model.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: start held or pulsed; accept spacing checked against the WIDTH+2 period.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(4)) bus4 ();
    serial_adder_if #(.WIDTH(8)) bus8 ();

    serial_adder #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    serial_adder #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    int checks = 0;
    int errors = 0;

    // Reference: plain integer arithmetic, unsigned for sum/cout, signed range test for ovf.
    task automatic model(input int w, input int ua, input int ub, input bit s,
                         output int es, output bit ec, output bit eo, output bit ez);
        int m;
        int half;
        int r;
        int sa;
        int sb;
        int sr;
        m    = 1 << w;
        half = m / 2;
        r    = s ? ua - ub : ua + ub;
        ec   = s ? (ua >= ub) : (r >= m);
        es   = ((r % m) + m) % m;
        sa   = (ua >= half) ? ua - m : ua;
        sb   = (ub >= half) ? ub - m : ub;
        sr   = s ? sa - sb : sa + sb;
        eo   = (sr < -half) || (sr >= half);
        ez   = (es == 0);
    endtask

    task automatic run_op4(input int ua, input int ub, input bit s);
        int cycles;
        int busy_n;
        int es;
        bit ec, eo, ez;
        logic [6:0] exp_v;
        model(4, ua, ub, s, es, ec, eo, ez);
        exp_v = {4'(es), ec, eo, ez};
        bus4.start = 1'b1;
        bus4.a     = 4'(ua);
        bus4.b     = 4'(ub);
        bus4.sub   = s;
        @(negedge clk);
        bus4.start = 1'b0;
        cycles = 1;
        busy_n = 0;
        while (bus4.done !== 1'b1 && cycles < 20) begin
            if (bus4.busy === 1'b1) busy_n++;
            // Operand churn while shifting must not disturb the result.
            bus4.a   = 4'($urandom);
            bus4.b   = 4'($urandom);
            bus4.sub = 1'($urandom);
            @(negedge clk);
            cycles++;
        end
        checks++;
        if (cycles !== 5)
            $display("FAIL w4_latency %0h%s%0h: got %0d cycles, want 5", ua, s ? "-" : "+", ub, cycles);
        checks++;
        if (busy_n !== 4)
            $display("FAIL w4_busy_len %0h%s%0h: got %0d, want 4", ua, s ? "-" : "+", ub, busy_n);
        checks++;
        if ({bus4.sum, bus4.cout, bus4.ovf, bus4.zero} !== exp_v) begin
            errors++;
            $display("FAIL w4_result %0h%s%0h: got sum=%0h c=%b v=%b z=%b, want sum=%0h c=%b v=%b z=%b",
                     ua, s ? "-" : "+", ub, bus4.sum, bus4.cout, bus4.ovf, bus4.zero, es, ec, eo, ez);
        end
        if (cycles !== 5 || busy_n !== 4) errors += ((cycles !== 5) ? 1 : 0) + ((busy_n !== 4) ? 1 : 0);
        @(negedge clk);
        checks++;
        if ({bus4.done, bus4.busy, bus4.sum, bus4.cout, bus4.ovf, bus4.zero} !== {2'b00, exp_v}) begin
            errors++;
            $display("FAIL w4_after_done: got done=%b busy=%b sum=%0h, want done=0 busy=0 sum=%0h (held)",
                     bus4.done, bus4.busy, bus4.sum, es);
        end
    endtask

    task automatic run_op8(input int ua, input int ub, input bit s);
        int cycles;
        int es;
        bit ec, eo, ez;
        model(8, ua, ub, s, es, ec, eo, ez);
        bus8.start = 1'b1;
        bus8.a     = 8'(ua);
        bus8.b     = 8'(ub);
        bus8.sub   = s;
        @(negedge clk);
        bus8.start = 1'b0;
        cycles = 1;
        while (bus8.done !== 1'b1 && cycles < 30) begin
            bus8.a = 8'($urandom);
            bus8.b = 8'($urandom);
            @(negedge clk);
            cycles++;
        end
        checks++;
        if (cycles !== 9) begin
            errors++;
            $display("FAIL w8_latency %0h%s%0h: got %0d cycles, want 9", ua, s ? "-" : "+", ub, cycles);
        end
        checks++;
        if ({bus8.sum, bus8.cout, bus8.ovf, bus8.zero} !== {8'(es), ec, eo, ez}) begin
            errors++;
            $display("FAIL w8_result %0h%s%0h: got sum=%0h c=%b v=%b z=%b, want sum=%0h c=%b v=%b z=%b",
                     ua, s ? "-" : "+", ub, bus8.sum, bus8.cout, bus8.ovf, bus8.zero, es, ec, eo, ez);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus4.start = 1'b1;
        bus4.a     = 4'h5;
        bus4.b     = 4'h3;
        bus4.sub   = 1'b0;
        bus8.start = 1'b1;
        bus8.a     = 8'h11;
        bus8.b     = 8'h22;
        bus8.sub   = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus4.busy, bus4.done, bus4.sum, bus4.cout, bus4.ovf, bus4.zero} !== 9'b0) begin
            errors++;
            $display("FAIL reset_w4: got busy=%b done=%b sum=%0h c=%b v=%b z=%b, want all 0",
                     bus4.busy, bus4.done, bus4.sum, bus4.cout, bus4.ovf, bus4.zero);
        end
        checks++;
        if ({bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.ovf, bus8.zero} !== 13'b0) begin
            errors++;
            $display("FAIL reset_w8: got busy=%b done=%b sum=%0h, want all 0", bus8.busy, bus8.done, bus8.sum);
        end
        rst        = 1'b0;
        bus4.start = 1'b0;
        bus8.start = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus4.busy, bus4.done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_no_start: got busy=%b done=%b, want 0 0", bus4.busy, bus4.done);
        end
    endtask

    task automatic test_add();
        run_op4(4'h7, 4'h9, 1'b0);
        run_op4(4'h7, 4'h1, 1'b0);
        run_op4(4'hF, 4'h1, 1'b0);
    endtask

    task automatic test_sub();
        run_op4(3, 5, 1'b1);
        run_op4(5, 3, 1'b1);
        run_op4(4'h8, 4'h1, 1'b1);
        run_op4(4'h0, 4'h0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++)
            run_op4($urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom));
    endtask

    // start held high: accepts must land exactly every 6 cycles, each result
    // must belong to the operands presented on its accept cycle.
    task automatic test_back_to_back();
        int opa[36];
        int opb[36];
        bit ops[36];
        int es;
        bit ec, eo, ez;
        logic [1:0] exp_bd;
        for (int t = 0; t < 36; t++) begin
            exp_bd = (t % 6 == 5) ? 2'b01 : ((t % 6 == 0) ? 2'b00 : 2'b10);
            checks++;
            if ({bus4.busy, bus4.done} !== exp_bd) begin
                errors++;
                $display("FAIL b2b_status t=%0d: got busy=%b done=%b, want %b", t, bus4.busy, bus4.done, exp_bd);
            end
            if (t % 6 == 5) begin
                model(4, opa[t-5], opb[t-5], ops[t-5], es, ec, eo, ez);
                checks++;
                if ({bus4.sum, bus4.cout, bus4.ovf, bus4.zero} !== {4'(es), ec, eo, ez}) begin
                    errors++;
                    $display("FAIL b2b_result t=%0d: got sum=%0h c=%b v=%b z=%b, want sum=%0h c=%b v=%b z=%b",
                             t, bus4.sum, bus4.cout, bus4.ovf, bus4.zero, es, ec, eo, ez);
                end
            end
            opa[t] = $urandom_range(0, 15);
            opb[t] = $urandom_range(0, 15);
            ops[t] = 1'($urandom);
            bus4.start = (t < 35);
            bus4.a     = 4'(opa[t]);
            bus4.b     = 4'(opb[t]);
            bus4.sub   = ops[t];
            @(negedge clk);
        end
        bus4.start = 1'b0;
    endtask

    task automatic test_reset_mid();
        int done_n;
        run_op4(4'h7, 4'h1, 1'b0);
        bus4.start = 1'b1;
        bus4.a     = 4'h6;
        bus4.b     = 4'h6;
        bus4.sub   = 1'b0;
        @(negedge clk);
        bus4.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus4.busy, bus4.done, bus4.sum, bus4.cout, bus4.ovf, bus4.zero} !== 9'b0) begin
            errors++;
            $display("FAIL midreset_clear: got busy=%b done=%b sum=%0h c=%b v=%b z=%b, want all 0",
                     bus4.busy, bus4.done, bus4.sum, bus4.cout, bus4.ovf, bus4.zero);
        end
        done_n = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus4.done === 1'b1) done_n++;
            @(negedge clk);
        end
        checks++;
        if (done_n !== 0) begin
            errors++;
            $display("FAIL midreset_no_done: got %0d done pulses, want 0", done_n);
        end
        run_op4(4'h6, 4'h6, 1'b0);
    endtask

    task automatic test_width8();
        run_op8(8'h7F, 8'h01, 1'b0);
        run_op8(8'hFF, 8'h01, 1'b0);
        run_op8(8'h03, 8'h05, 1'b1);
        run_op8(8'h80, 8'h01, 1'b1);
        for (int i = 0; i < 10; i++)
            run_op8($urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus4.start = 1'b0;
        bus4.sub   = 1'b0;
        bus4.a     = '0;
        bus4.b     = '0;
        bus8.start = 1'b0;
        bus8.sub   = 1'b0;
        bus8.a     = '0;
        bus8.b     = '0;
        rst        = 1'b1;
        @(negedge clk);
        test_reset();
        test_add();
        test_sub();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_width8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
